// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction classes, FSM
// state encoding, instruction field positions and ALU opcode constants.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } seq_state_t;

    localparam logic [2:0] CLS_ALU  = 3'd0;
    localparam logic [2:0] CLS_LI   = 3'd1;
    localparam logic [2:0] CLS_NOP  = 3'd2;
    localparam logic [2:0] CLS_CMPZ = 3'd3;

    localparam int CLS_HI = 31;
    localparam int CLS_LO = 29;
    localparam int OPC_HI = 28;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLL  = 3'd5;
    localparam logic [2:0] OP_SRL  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Classes 4..7 are reserved; the top class bit alone marks them illegal.
    function automatic logic cls_is_legal(input logic [2:0] cls);
        return (cls[2] == 1'b0);
    endfunction

    function automatic logic cls_uses_alu(input logic [2:0] cls);
        return (cls == CLS_ALU) || (cls == CLS_CMPZ);
    endfunction

endpackage

// File: rtl/instr_sequencer_field_decode.sv
// Combinational split of a 32-bit instruction word into its fields plus an
// illegal-class flag.
module instr_field_decode
    import instr_sequencer_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [2:0]  o_class,
    output logic [2:0]  o_opcode,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [15:0] o_imm,
    output logic        o_is_illegal
);

    assign o_class      = i_instr[CLS_HI:CLS_LO];
    assign o_opcode     = i_instr[OPC_HI:OPC_LO];
    assign o_rd         = i_instr[RD_HI:RD_LO];
    assign o_rs1        = i_instr[RS1_HI:RS1_LO];
    assign o_rs2        = i_instr[RS2_HI:RS2_LO];
    assign o_imm        = i_instr[IMM_HI:IMM_LO];
    assign o_is_illegal = !cls_is_legal(i_instr[CLS_HI:CLS_LO]);

endmodule

// File: rtl/instr_sequencer.sv
// Decode/Execute/Writeback sequencer driving the register-file/ALU datapath.
// Optional build macro INSTR_SEQ_ZERO_REG_EN makes r0 a constant-zero register.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int COUNT_W     = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Instr_Valid,
    output logic               Instr_Ready,
    input  logic [31:0]        Instr,
    input  logic               Alu_Zero,
    output logic [4:0]         Read_Addr_1,
    output logic [4:0]         Read_Addr_2,
    output logic [4:0]         Write_Addr,
    output logic               Write_Enable,
    output logic               Mux_ctrl,
    output logic [2:0]         Opcode,
    output logic [31:0]        Imm_Data,
    output logic               Busy,
    output logic               Zero_Flag,
    output logic               Illegal,
    output logic [COUNT_W-1:0] Retired_Count
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    seq_state_t         r_state;
    logic [31:0]        r_instr;
    logic [3:0]         r_exec_cnt;
    logic               r_ready;
    logic [4:0]         r_ra1;
    logic [4:0]         r_ra2;
    logic [4:0]         r_wa;
    logic               r_we;
    logic               r_mux;
    logic [2:0]         r_opcode;
    logic [31:0]        r_imm;
    logic               r_busy;
    logic               r_zero;
    logic               r_illegal;
    logic [COUNT_W-1:0] r_count;

    logic [2:0]  w_class;
    logic [2:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [15:0] w_imm;
    logic        w_is_illegal;
    logic        w_uses_alu;
    logic        w_rd_writable;

    instr_field_decode u_field_decode (
        .i_instr      (r_instr),
        .o_class      (w_class),
        .o_opcode     (w_opcode),
        .o_rd         (w_rd),
        .o_rs1        (w_rs1),
        .o_rs2        (w_rs2),
        .o_imm        (w_imm),
        .o_is_illegal (w_is_illegal)
    );

    assign w_uses_alu = cls_uses_alu(w_class);

`ifdef INSTR_SEQ_ZERO_REG_EN
    assign w_rd_writable = (w_rd != 5'd0);
`else
    assign w_rd_writable = 1'b1;
`endif

    // Sequencer FSM; every datapath control is produced here as a register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_instr    <= 32'd0;
            r_exec_cnt <= 4'd0;
            r_ready    <= 1'b0;
            r_ra1      <= 5'd0;
            r_ra2      <= 5'd0;
            r_wa       <= 5'd0;
            r_we       <= 1'b0;
            r_mux      <= 1'b0;
            r_opcode   <= 3'd0;
            r_imm      <= 32'd0;
            r_busy     <= 1'b0;
            r_zero     <= 1'b0;
            r_illegal  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Instr_Valid && r_ready) begin
                        r_instr <= Instr;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_DECODE;
                    end else begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    // Outputs are loaded here and then held through WB and IDLE.
                    r_ra1    <= w_rs1;
                    r_ra2    <= w_rs2;
                    r_wa     <= w_rd;
                    r_imm    <= {16'h0000, w_imm};
                    r_mux    <= w_uses_alu;
                    r_opcode <= w_uses_alu ? w_opcode : OP_ADD;
                    if (w_is_illegal) begin
                        r_illegal <= 1'b1;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_uses_alu) begin
                        r_exec_cnt <= EXEC_LOAD;
                        r_state    <= ST_EXEC;
                    end else begin
                        r_we    <= (w_class == CLS_LI) && w_rd_writable;
                        r_state <= ST_WB;
                    end
                end
                ST_EXEC: begin
                    if (r_exec_cnt == 4'd0) begin
                        r_zero  <= Alu_Zero;
                        r_we    <= (w_class == CLS_ALU) && w_rd_writable;
                        r_state <= ST_WB;
                    end else begin
                        r_exec_cnt <= r_exec_cnt - 4'd1;
                    end
                end
                ST_WB: begin
                    r_count <= r_count + COUNT_W'(1);
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Instr_Ready   = r_ready;
    assign Read_Addr_1   = r_ra1;
    assign Read_Addr_2   = r_ra2;
    assign Write_Addr    = r_wa;
    assign Write_Enable  = r_we;
    assign Mux_ctrl      = r_mux;
    assign Opcode        = r_opcode;
    assign Imm_Data      = r_imm;
    assign Busy          = r_busy;
    assign Zero_Flag     = r_zero;
    assign Illegal       = r_illegal;
    assign Retired_Count = r_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (EXEC_CYCLES=2, COUNT_W=4).
module tb_instr_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [31:0] Instr;
    logic        Alu_Zero;
    logic [4:0]  Read_Addr_1;
    logic [4:0]  Read_Addr_2;
    logic [4:0]  Write_Addr;
    logic        Write_Enable;
    logic        Mux_ctrl;
    logic [2:0]  Opcode;
    logic [31:0] Imm_Data;
    logic        Busy;
    logic        Zero_Flag;
    logic        Illegal;
    logic [3:0]  Retired_Count;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations from the most recent instruction run.
    int          ob_edges;
    int          ob_we_n;
    logic [4:0]  ob_wa;
    logic [4:0]  ob_ra1;
    logic [4:0]  ob_ra2;
    logic [2:0]  ob_op;
    logic        ob_mux;
    logic [31:0] ob_imm;

    instr_sequencer #(.EXEC_CYCLES(2), .COUNT_W(4)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Instr_Valid   (Instr_Valid),
        .Instr_Ready   (Instr_Ready),
        .Instr         (Instr),
        .Alu_Zero      (Alu_Zero),
        .Read_Addr_1   (Read_Addr_1),
        .Read_Addr_2   (Read_Addr_2),
        .Write_Addr    (Write_Addr),
        .Write_Enable  (Write_Enable),
        .Mux_ctrl      (Mux_ctrl),
        .Opcode        (Opcode),
        .Imm_Data      (Imm_Data),
        .Busy          (Busy),
        .Zero_Flag     (Zero_Flag),
        .Illegal       (Illegal),
        .Retired_Count (Retired_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] mk(input logic [2:0] cls, input logic [2:0] op,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [15:0] imm);
        return {cls, op, rd, rs1, imm};
    endfunction

    // Starts at a negedge with Instr_Ready high; returns at the negedge where it is high again.
    task automatic run_instr(input logic [31:0] ins, input bit keep_valid);
        Instr_Valid = 1'b1;
        Instr       = ins;
        @(posedge Clock);
        ob_edges = 1;
        @(negedge Clock);
        if (!keep_valid) Instr_Valid = 1'b0;
        Instr   = 32'hFFFF_FFFF;
        ob_we_n = 0;
        while (!Instr_Ready && ob_edges < 40) begin
            if (Write_Enable) begin
                ob_we_n++;
                ob_wa  = Write_Addr;
                ob_ra1 = Read_Addr_1;
                ob_ra2 = Read_Addr_2;
                ob_op  = Opcode;
                ob_mux = Mux_ctrl;
                ob_imm = Imm_Data;
            end
            @(posedge Clock);
            ob_edges++;
            @(negedge Clock);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Instr_Valid = 1'b1; Instr = mk(3'd1, 3'd0, 5'd5, 5'd0, 16'h1234); Alu_Zero = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        n_cmp++;
        if ({Instr_Ready, Read_Addr_1, Read_Addr_2, Write_Addr, Write_Enable, Mux_ctrl, Opcode,
             Imm_Data, Busy, Zero_Flag, Illegal, Retired_Count} !== 65'd0) begin
            n_bad++; $display("FAIL reset_outputs ready=%b busy=%b cnt=%0d want all 0", Instr_Ready, Busy, Retired_Count);
        end
        Reset = 1'b0;
        @(posedge Clock); @(negedge Clock);
        n_cmp++;
        if (Instr_Ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset got %b want 1", Instr_Ready); end
        Instr_Valid = 1'b0;
    endtask

    task automatic test_li();
        run_instr(mk(3'd1, 3'd4, 5'd5, 5'd9, 16'h1234), 1'b0);
        n_cmp++; if (ob_edges !== 3) begin n_bad++; $display("FAIL li_latency got %0d want 3", ob_edges); end
        n_cmp++; if (ob_we_n !== 1) begin n_bad++; $display("FAIL li_we_pulses got %0d want 1", ob_we_n); end
        n_cmp++; if (ob_wa !== 5'd5) begin n_bad++; $display("FAIL li_waddr got %0d want 5", ob_wa); end
        n_cmp++; if (ob_imm !== 32'h0000_1234) begin n_bad++; $display("FAIL li_imm got %h want 00001234", ob_imm); end
        n_cmp++; if (ob_mux !== 1'b0) begin n_bad++; $display("FAIL li_mux got %b want 0", ob_mux); end
        n_cmp++; if (ob_op !== 3'd0) begin n_bad++; $display("FAIL li_opcode got %0d want 0", ob_op); end
        n_cmp++; if (Retired_Count !== 4'd1) begin n_bad++; $display("FAIL li_retired got %0d want 1", Retired_Count); end
    endtask

    task automatic test_alu();
        Alu_Zero = 1'b1;
        run_instr(mk(3'd0, 3'd1, 5'd3, 5'd1, 16'h1000), 1'b0);
        n_cmp++; if (ob_edges !== 5) begin n_bad++; $display("FAIL alu_latency got %0d want 5", ob_edges); end
        n_cmp++; if (ob_we_n !== 1) begin n_bad++; $display("FAIL alu_we_pulses got %0d want 1", ob_we_n); end
        n_cmp++; if (ob_wa !== 5'd3) begin n_bad++; $display("FAIL alu_waddr got %0d want 3", ob_wa); end
        n_cmp++; if (ob_ra1 !== 5'd1) begin n_bad++; $display("FAIL alu_raddr1 got %0d want 1", ob_ra1); end
        n_cmp++; if (ob_ra2 !== 5'd2) begin n_bad++; $display("FAIL alu_raddr2 got %0d want 2", ob_ra2); end
        n_cmp++; if (ob_op !== 3'd1) begin n_bad++; $display("FAIL alu_opcode got %0d want 1", ob_op); end
        n_cmp++; if (ob_mux !== 1'b1) begin n_bad++; $display("FAIL alu_mux got %b want 1", ob_mux); end
        n_cmp++; if (Zero_Flag !== 1'b1) begin n_bad++; $display("FAIL alu_zero got %b want 1", Zero_Flag); end
        n_cmp++; if (Retired_Count !== 4'd2) begin n_bad++; $display("FAIL alu_retired got %0d want 2", Retired_Count); end
        n_cmp++; if (Read_Addr_1 !== 5'd1) begin n_bad++; $display("FAIL alu_hold_raddr1 got %0d want 1", Read_Addr_1); end
    endtask

    task automatic test_cmpz_nop();
        Alu_Zero = 1'b0;
        run_instr(mk(3'd3, 3'd2, 5'd4, 5'd6, 16'h3800), 1'b0);
        n_cmp++; if (ob_edges !== 5) begin n_bad++; $display("FAIL cmpz_latency got %0d want 5", ob_edges); end
        n_cmp++; if (ob_we_n !== 0) begin n_bad++; $display("FAIL cmpz_we_pulses got %0d want 0", ob_we_n); end
        n_cmp++; if (Zero_Flag !== 1'b0) begin n_bad++; $display("FAIL cmpz_zero got %b want 0", Zero_Flag); end
        n_cmp++; if (Opcode !== 3'd2) begin n_bad++; $display("FAIL cmpz_opcode got %0d want 2", Opcode); end
        Alu_Zero = 1'b1;
        run_instr(mk(3'd2, 3'd5, 5'd8, 5'd7, 16'h0042), 1'b0);
        n_cmp++; if (ob_edges !== 3) begin n_bad++; $display("FAIL nop_latency got %0d want 3", ob_edges); end
        n_cmp++; if (ob_we_n !== 0) begin n_bad++; $display("FAIL nop_we_pulses got %0d want 0", ob_we_n); end
        n_cmp++; if (Zero_Flag !== 1'b0) begin n_bad++; $display("FAIL nop_zero_kept got %b want 0", Zero_Flag); end
        n_cmp++; if (Opcode !== 3'd0) begin n_bad++; $display("FAIL nop_opcode got %0d want 0", Opcode); end
        n_cmp++; if (Retired_Count !== 4'd4) begin n_bad++; $display("FAIL cmpz_nop_retired got %0d want 4", Retired_Count); end
    endtask

    task automatic test_illegal();
        run_instr(mk(3'd5, 3'd0, 5'd2, 5'd0, 16'h0001), 1'b0);
        n_cmp++; if (ob_edges !== 2) begin n_bad++; $display("FAIL ill_latency got %0d want 2", ob_edges); end
        n_cmp++; if (ob_we_n !== 0) begin n_bad++; $display("FAIL ill_we_pulses got %0d want 0", ob_we_n); end
        n_cmp++; if (Illegal !== 1'b1) begin n_bad++; $display("FAIL ill_flag got %b want 1", Illegal); end
        n_cmp++; if (Retired_Count !== 4'd4) begin n_bad++; $display("FAIL ill_retired got %0d want 4", Retired_Count); end
        run_instr(mk(3'd1, 3'd0, 5'd7, 5'd0, 16'hABCD), 1'b0);
        n_cmp++; if (ob_we_n !== 1) begin n_bad++; $display("FAIL post_ill_li_we got %0d want 1", ob_we_n); end
        n_cmp++; if (ob_imm !== 32'h0000_ABCD) begin n_bad++; $display("FAIL post_ill_li_imm got %h want 0000abcd", ob_imm); end
        n_cmp++; if (Illegal !== 1'b1) begin n_bad++; $display("FAIL ill_sticky got %b want 1", Illegal); end
        n_cmp++; if (Retired_Count !== 4'd5) begin n_bad++; $display("FAIL post_ill_retired got %0d want 5", Retired_Count); end
    endtask

    task automatic test_zero_reg();
        int exp_we;
`ifdef INSTR_SEQ_ZERO_REG_EN
        exp_we = 0;
`else
        exp_we = 1;
`endif
        run_instr(mk(3'd1, 3'd0, 5'd0, 5'd0, 16'h5555), 1'b0);
        n_cmp++; if (ob_we_n !== exp_we) begin n_bad++; $display("FAIL r0_write got %0d want %0d", ob_we_n, exp_we); end
        n_cmp++; if (Retired_Count !== 4'd6) begin n_bad++; $display("FAIL r0_retired got %0d want 6", Retired_Count); end
    endtask

    task automatic test_back_to_back();
        run_instr(mk(3'd1, 3'd0, 5'd10, 5'd0, 16'h0010), 1'b1);
        run_instr(mk(3'd1, 3'd0, 5'd11, 5'd0, 16'h0011), 1'b1);
        Instr_Valid = 1'b0;
        n_cmp++; if (ob_wa !== 5'd11) begin n_bad++; $display("FAIL b2b_waddr got %0d want 11", ob_wa); end
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        n_cmp++; if (Retired_Count !== 4'd8) begin n_bad++; $display("FAIL b2b_retired got %0d want 8", Retired_Count); end
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got %b want 0", Busy); end
    endtask

    task automatic test_reset_exec();
        int we_seen;
        we_seen = 0;
        Instr_Valid = 1'b1;
        Instr = mk(3'd0, 3'd3, 5'd9, 5'd4, 16'h2800);
        @(posedge Clock); @(negedge Clock);
        Instr_Valid = 1'b0;
        @(posedge Clock); @(negedge Clock);
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL rexec_busy got %b want 1", Busy); end
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); @(negedge Clock);
            if (Write_Enable) we_seen++;
        end
        n_cmp++; if (we_seen !== 0) begin n_bad++; $display("FAIL rexec_we got %0d want 0", we_seen); end
        n_cmp++;
        if ({Instr_Ready, Read_Addr_1, Read_Addr_2, Write_Addr, Write_Enable, Mux_ctrl, Opcode,
             Imm_Data, Busy, Zero_Flag, Illegal, Retired_Count} !== 65'd0) begin
            n_bad++; $display("FAIL rexec_outputs ill=%b zf=%b cnt=%0d ra1=%0d want all 0", Illegal, Zero_Flag, Retired_Count, Read_Addr_1);
        end
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); @(negedge Clock);
            if (Write_Enable) we_seen++;
        end
        n_cmp++; if (we_seen !== 0) begin n_bad++; $display("FAIL rexec_we_after got %0d want 0", we_seen); end
        n_cmp++; if (Instr_Ready !== 1'b1) begin n_bad++; $display("FAIL rexec_ready got %b want 1", Instr_Ready); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 15; i++) run_instr(mk(3'd2, 3'd0, 5'd1, 5'd0, 16'h0000), 1'b1);
        n_cmp++; if (Retired_Count !== 4'd15) begin n_bad++; $display("FAIL wrap_15 got %0d want 15", Retired_Count); end
        run_instr(mk(3'd2, 3'd0, 5'd1, 5'd0, 16'h0000), 1'b1);
        Instr_Valid = 1'b0;
        n_cmp++; if (Retired_Count !== 4'd0) begin n_bad++; $display("FAIL wrap_16 got %0d want 0", Retired_Count); end
        n_cmp++; if (Illegal !== 1'b0) begin n_bad++; $display("FAIL wrap_no_stray_accept got %b want 0", Illegal); end
    endtask

    initial begin
        test_reset();
        test_li();
        test_alu();
        test_cmpz_nop();
        test_illegal();
        test_zero_reg();
        test_back_to_back();
        test_reset_exec();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
